// File: rtl/seg_chase_monitor_if.sv
// seg_chase_monitor_if: segment lines into the chase monitor and decoded chase status out of it
interface seg_chase_monitor_if;
    logic [6:0] seg_in;
    logic [2:0] pos;
    logic       dir;
    logic       step_pulse;
    logic       locked;
    logic [7:0] step_period;
    modport master (output seg_in, input pos, dir, step_pulse, locked, step_period);
    modport slave (input seg_in, output pos, dir, step_pulse, locked, step_period);
endinterface

// File: rtl/seg_chase_monitor.sv
// seg_chase_monitor: PWM chase-display receiver (head segment, position, direction, lock); SEG_MON_PERIOD_EN adds step_period
module seg_chase_monitor #(
    parameter int WINDOW_WIDTH = 10,
    parameter int DUTY_WIDTH   = 5,
    parameter int MIN_DUTY     = 4,
    parameter int LOCK_STEPS   = 3,
    parameter bit COMMON_ANODE = 1'b1
) (
    input logic                clk,
    input logic                reset,
    seg_chase_monitor_if.slave bus
);
    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;
    localparam int         CW       = WINDOW_WIDTH + 1;
    localparam int         CNTW     = $clog2(LOCK_STEPS + 1);
    localparam logic [6:0] IDLE_LVL = COMMON_ANODE ? 7'h7F : 7'h00;
    localparam logic [2:0] NONE     = 3'd7;
    logic [6:0]              s1_q, s2_q, on;
    logic [WINDOW_WIDTH-1:0] win_q;
    logic                    close, eval_q;
    logic [CW-1:0]           on_cnt_q [7];
    logic [DUTY_WIDTH-1:0]   duty_q [7];
    logic [DUTY_WIDTH-1:0]   best;
    logic [2:0]              head, prev_head_q, new_pos, delta;
    logic                    dark, is_fwd, is_step, is_jump, same;
    state_t                  state_q, state_d;
    logic [2:0]              pos_q, pos_d;
    logic                    dir_q, dir_d, pulse_q, pulse_d;
    logic [CNTW-1:0]         cnt_q, cnt_d;
    // two-flop synchronizer, parked at the "off" level so reset never reads as lit
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= IDLE_LVL;
            s2_q <= IDLE_LVL;
        end else begin
            s1_q <= bus.seg_in;
            s2_q <= s1_q;
        end
    end
    assign on    = COMMON_ANODE ? ~s2_q : s2_q;
    assign close = &win_q;
    // per-segment on-time over each window; duty captured at close, counters restart with the close sample
    always_ff @(posedge clk) begin
        if (reset) begin
            win_q  <= '0;
            eval_q <= 1'b0;
            for (int i = 0; i < 7; i++) begin
                on_cnt_q[i] <= '0;
                duty_q[i]   <= '0;
            end
        end else begin
            win_q  <= win_q + 1'b1;
            eval_q <= close;
            for (int i = 0; i < 7; i++) begin
                on_cnt_q[i] <= close ? CW'(on[i]) : on_cnt_q[i] + CW'(on[i]);
                if (close) duty_q[i] <= on_cnt_q[i][CW-1] ? '1 : on_cnt_q[i][CW-1 -: DUTY_WIDTH];
            end
        end
    end
    // brightest segment, lowest index wins ties; too dim means no head
    always_comb begin
        head = 3'd0;
        best = duty_q[0];
        for (int i = 1; i < 7; i++) begin
            if (duty_q[i] > best) begin
                best = duty_q[i];
                head = 3'(i);
            end
        end
        if (best < DUTY_WIDTH'(MIN_DUTY)) head = NONE;
    end
    // segment-to-position decode; g sits at two positions and is resolved from the previous head
    always_comb begin
        new_pos = head == 3'd0 ? 3'd0 : head == 3'd1 ? 3'd1 : head == 3'd2 ? 3'd5 :
                  head == 3'd3 ? 3'd4 : head == 3'd4 ? 3'd3 : head == 3'd5 ? 3'd7 :
                  (prev_head_q == 3'd2 || prev_head_q == 3'd5) ? 3'd6 : 3'd2;
        dark    = head == NONE;
        delta   = new_pos - pos_q;
        is_fwd  = delta == 3'd1;
        is_step = is_fwd || delta == 3'd7;
        is_jump = delta != 3'd0 && !is_step;
        same    = is_step && (cnt_q == '0 || is_fwd == dir_q);
    end
    // state and tracking registers; they only move on the cycle a window result is evaluated
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SEARCH;
            pos_q       <= '0;
            dir_q       <= 1'b0;
            pulse_q     <= 1'b0;
            cnt_q       <= '0;
            prev_head_q <= NONE;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
            if (eval_q) prev_head_q <= head;
        end
    end
    // next state: dark always drops to SEARCH, lock needs LOCK_STEPS same-direction steps
    always_comb begin
        state_d = !eval_q ? state_q :
                  dark ? SEARCH :
                  state_q == SEARCH ? TRACK :
                  state_q == TRACK ? ((same && cnt_q == CNTW'(LOCK_STEPS - 1)) ? LOCKED : TRACK) :
                  (delta == 3'd0 || same) ? LOCKED : TRACK;
    end
    // position, direction, step run length and step strobe for the evaluated window
    always_comb begin
        pos_d   = pos_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (eval_q && !dark) begin
            pos_d = new_pos;
            if (state_q == SEARCH) begin
                cnt_d = '0;
            end else if (is_step) begin
                pulse_d = 1'b1;
                dir_d   = is_fwd;
                cnt_d   = !same ? CNTW'(1) : cnt_q == CNTW'(LOCK_STEPS) ? cnt_q : cnt_q + 1'b1;
            end else if (is_jump) begin
                cnt_d = '0;
            end
        end
    end
    assign bus.pos        = pos_q;
    assign bus.dir        = dir_q;
    assign bus.step_pulse = pulse_q;
    assign bus.locked     = state_q == LOCKED;
`ifdef SEG_MON_PERIOD_EN
    logic [7:0] since_q, period_q, since_inc;
    assign since_inc = &since_q ? since_q : since_q + 8'd1;
    // windows elapsed since the previous step, latched alongside each step strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            since_q  <= '0;
            period_q <= '0;
        end else if (eval_q) begin
            since_q <= pulse_d ? 8'd0 : since_inc;
            if (pulse_d) period_q <= since_inc;
        end
    end
    assign bus.step_period = period_q;
`else
    assign bus.step_period = 8'd0;
`endif
endmodule
